txfifo_rd_framer: RTL and testbench
===================================

// Module: txfifo_rd_framer
// PURPOSE
//  Read-side engine for the 1024x64 TX FIFO, in the rdclk domain. Pops a length descriptor,
//  then the packet's data words. Drives a valid/ready 64-bit stream with SOP/EOP/MOD framing
//  toward the MAC transmit path. Drops bad-length packets.
// PARAMETERS
//  WIDTH    64    data word width (fixed 8 bytes/word)
//  LEN_W    16    descriptor length field width, bits [LEN_W-1:0] of descriptor word
//  MAX_LEN  9600  largest legal packet length in bytes
// PORTS
//  clk           in   1      clock (FIFO rdclk)
//  reset_        in   1      synchronous, active-low reset
//  fifo_rdreq    out  1      TX FIFO read request
//  fifo_q        in   WIDTH  TX FIFO read data
//  fifo_rdempty  in   1      TX FIFO empty
//  tx_rdy        in   1      downstream ready
//  tx_val        out  1      stream word valid
//  tx_data       out  WIDTH  stream data; byte 0 in [7:0]
//  tx_sop        out  1      first word of packet
//  tx_eop        out  1      last word of packet
//  tx_mod        out  3      valid bytes in EOP word, 0 = all 8; 0 on non-EOP words
//  busy          out  1      FSM not IDLE or output buffer non-empty
//  len_err       out  1      1-cycle pulse on illegal descriptor
// BEHAVIOUR
//  - Reset: all outputs 0. FSM=IDLE, buffer empty, in-flight tags cleared. Reset mid-packet
//    abandons the packet; FIFO is not flushed here (upstream asserts aclr with reset_).
//  - FIFO read: fifo_q valid exactly 1 clk after an edge with fifo_rdreq=1.
//    fifo_rdreq never asserted while fifo_rdempty=1.
//  - Each issued read is tagged HDR/DATA/DROP. Only DATA words enter the 2-entry output buffer.
//  - Read issue allowed only while (buffer occupancy + DATA reads in flight) < 2, so no overflow.
//  - Descriptor: len = q[LEN_W-1:0]; upper bits ignored. words = (len+7)>>3.
//  - FSM:
//    IDLE: !fifo_rdempty -> issue HDR read -> HDR.
//    HDR: capture len next clk.
//      len==0: len_err, -> IDLE.
//      len>MAX_LEN: len_err, rem=words, -> DROP.
//      else rem=words, -> DATA.
//    DATA: issue a DATA read whenever space allows and FIFO not empty; rem-- per issue.
//      Last issue -> IDLE, so the next descriptor read may overlap the drain.
//    DROP: issue reads each clk while FIFO not empty; discard; rem--; rem hits 0 -> IDLE.
//  - Output handshake: a word transfers on tx_val&&tx_rdy. While tx_val&&!tx_rdy,
//    tx_data/sop/eop/mod are held stable.
//  - Framing: tx_sop on first DATA word only; tx_eop on word #words; tx_mod=len[2:0] on EOP.
//  - Throughput: with tx_rdy=1 and FIFO non-empty, 1 word/clk within a packet. At most
//    1 bubble clk between packets (descriptor).
//  - FIFO empty mid-packet: tx_val deasserts (gap), resumes without repeating tx_sop.
//  - Length arithmetic is LEN_W+1 bits wide; no overflow at len=2^LEN_W-1.
// CONFIGURATION
//  TXRD_STATS_EN defined: adds outputs pkt_cnt[31:0] and byte_cnt[31:0], reset to 0.
//    On each accepted EOP transfer: pkt_cnt+=1, byte_cnt+=len. Both wrap mod 2^32.
//    Dropped/len_err packets are not counted.
//  Not defined: ports and counters absent. All other behaviour identical.
// TESTING
//  1 reset_=0 for 4 clk, FIFO non-empty -> fifo_rdreq=0, tx_val=0, all outputs 0, busy=0.
//  2 desc len=20 + 3 words, tx_rdy=1 -> 3 consecutive beats; sop on beat1, eop on beat3,
//    tx_mod=4; data matches.
//  3 two len=64 pkts back-to-back, tx_rdy toggling 1/0 each clk -> 16 beats in order;
//    no loss or dup; data stable while stalled; tx_mod=0 on both EOPs.
//  4 desc len=0 then len=8 pkt -> len_err 1 clk, no beat for len=0; then 1 beat with
//    sop=eop=1, mod=0.
//  5 desc len=10000 + 1250 words, then len=20 pkt -> len_err; 1250 words read, tx_val=0
//    throughout; next pkt intact.
//  6 TXRD_STATS_EN, run 2 then 3 -> pkt_cnt=3, byte_cnt=148. Assert FIFO underrun stall
//    holds sop=0 on resume.

Source files
------------

// File: rtl/txfifo_rd_framer.sv
// txfifo_rd_framer: read-side engine for the 1024x64 TX FIFO (rdclk domain).
// Pops a length descriptor, then the packet's data words, and presents them as a
// valid/ready stream with SOP/EOP/MOD framing. Illegal lengths are dropped.
// Optional build macro: TXRD_STATS_EN adds pkt_cnt/byte_cnt outputs.
module txfifo_rd_framer #(
    parameter int WIDTH   = 64,
    parameter int LEN_W   = 16,
    parameter int MAX_LEN = 9600
) (
    input  logic             clk,
    input  logic             reset_,
    output logic             fifo_rdreq,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_rdempty,
    input  logic             tx_rdy,
    output logic             tx_val,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic [2:0]       tx_mod,
    output logic             busy,
    output logic             len_err
`ifdef TXRD_STATS_EN
    ,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      byte_cnt
`endif
);

    // Word count of a LEN_W-bit length: (len+7)>>3 needs LEN_W+1 bits before the shift.
    localparam int REM_W = LEN_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;
    typedef enum logic [1:0] {TG_NONE, TG_HDR, TG_DATA, TG_DROP} tag_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
        logic [2:0]       mod;
    } beat_t;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic [2:0]       mod_q, mod_d;
    logic             len_err_q, len_err_d;

    // Tag and framing of the read issued last cycle; its word is on fifo_q now.
    tag_t             tag_q, tag_d;
    logic             isop_q, isop_d;
    logic             ieop_q, ieop_d;
    logic [2:0]       imod_q, imod_d;

    beat_t            obuf_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       occ_q;

    logic             issue, pop, push, inflight, room, can_data, too_big;
    logic [2:0]       fill;
    logic [LEN_W-1:0] len_in;
    logic [REM_W-1:0] words_in;
    beat_t            head;

    assign head    = obuf_q[rd_ptr_q];
    assign tx_val  = (occ_q != 2'd0);
    assign tx_data = head.data;
    assign tx_sop  = head.sop;
    assign tx_eop  = head.eop;
    assign tx_mod  = head.mod;
    assign len_err = len_err_q;
    // A DATA word still in flight counts as buffered, so busy never dips mid-drain.
    assign busy    = (state_q != S_IDLE) || (occ_q != 2'd0) || (tag_q == TG_DATA);
    assign fifo_rdreq = issue;

    assign pop      = tx_val && tx_rdy;
    assign push     = (tag_q == TG_DATA);
    assign inflight = (tag_q == TG_DATA);
    // Space check credits this cycle's pop so a full-rate stream keeps 1 word/clk.
    assign fill     = {1'b0, occ_q} + {2'b0, inflight} - {2'b0, pop};
    assign room     = (fill < 3'd2);
    assign can_data = room && !fifo_rdempty;
    assign len_in   = fifo_q[LEN_W-1:0];
    assign words_in = REM_W'(({1'b0, len_in} + (LEN_W+1)'(7)) >> 3);
    assign too_big  = ({1'b0, len_in} > (LEN_W+1)'(MAX_LEN));

    // Next-state, read issue and per-read framing tags.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        first_d   = first_q;
        mod_d     = mod_q;
        len_err_d = 1'b0;
        issue     = 1'b0;
        tag_d     = TG_NONE;
        isop_d    = 1'b0;
        ieop_d    = 1'b0;
        imod_d    = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_rdempty) begin
                    issue   = 1'b1;
                    tag_d   = TG_HDR;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                // Descriptor is on fifo_q this cycle; the first data read may go out now.
                mod_d = len_in[2:0];
                if (len_in == '0) begin
                    len_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (too_big) begin
                    len_err_d = 1'b1;
                    rem_d     = words_in;
                    state_d   = S_DROP;
                end else if (can_data) begin
                    issue   = 1'b1;
                    tag_d   = TG_DATA;
                    isop_d  = 1'b1;
                    ieop_d  = (words_in == REM_W'(1));
                    imod_d  = ieop_d ? len_in[2:0] : 3'd0;
                    rem_d   = words_in - REM_W'(1);
                    first_d = 1'b0;
                    state_d = ieop_d ? S_IDLE : S_DATA;
                end else begin
                    rem_d   = words_in;
                    first_d = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (can_data) begin
                    issue   = 1'b1;
                    tag_d   = TG_DATA;
                    isop_d  = first_q;
                    ieop_d  = (rem_q == REM_W'(1));
                    imod_d  = ieop_d ? mod_q : 3'd0;
                    rem_d   = rem_q - REM_W'(1);
                    first_d = 1'b0;
                    if (ieop_d) state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (!fifo_rdempty) begin
                    issue = 1'b1;
                    tag_d = TG_DROP;
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!reset_) begin
            issue = 1'b0;
            tag_d = TG_NONE;
        end
    end

    // FSM state, packet counters and in-flight read tag.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            first_q   <= 1'b0;
            mod_q     <= 3'd0;
            len_err_q <= 1'b0;
            tag_q     <= TG_NONE;
            isop_q    <= 1'b0;
            ieop_q    <= 1'b0;
            imod_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            mod_q     <= mod_d;
            len_err_q <= len_err_d;
            tag_q     <= tag_d;
            isop_q    <= isop_d;
            ieop_q    <= ieop_d;
            imod_q    <= imod_d;
        end
    end

    // Two-entry output buffer; the head entry stays put while the sink stalls.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            obuf_q[0] <= '0;
            obuf_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push) begin
                obuf_q[wr_ptr_q] <= '{data: fifo_q, sop: isop_q, eop: ieop_q, mod: imod_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef TXRD_STATS_EN
    logic [31:0] pkt_cnt_q, byte_cnt_q, pkt_bytes_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign byte_cnt = byte_cnt_q;

    // Per-packet byte tally, committed to the totals only on the EOP transfer.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            pkt_bytes_q <= '0;
        end else if (pop) begin
            if (head.eop) begin
                pkt_cnt_q   <= pkt_cnt_q + 32'd1;
                byte_cnt_q  <= byte_cnt_q + pkt_bytes_q +
                               ((head.mod == 3'd0) ? 32'd8 : {29'd0, head.mod});
                pkt_bytes_q <= '0;
            end else begin
                pkt_bytes_q <= pkt_bytes_q + 32'd8;
            end
        end
    end
`endif

endmodule

// File: tb/tb_txfifo_rd_framer.sv
// Directed bench for txfifo_rd_framer: behavioural FIFO in front, scoreboard behind.
module tb_txfifo_rd_framer;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        fifo_rdreq;
    logic [63:0] fifo_q = '0;
    logic        fifo_rdempty;
    logic        tx_rdy = 1'b1;
    logic        tx_val;
    logic [63:0] tx_data;
    logic        tx_sop, tx_eop;
    logic [2:0]  tx_mod;
    logic        busy, len_err;
`ifdef TXRD_STATS_EN
    logic [31:0] pkt_cnt, byte_cnt;
`endif

    txfifo_rd_framer dut (
        .clk(clk), .reset_(reset_), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
        .fifo_rdempty(fifo_rdempty), .tx_rdy(tx_rdy), .tx_val(tx_val), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_mod(tx_mod), .busy(busy), .len_err(len_err)
`ifdef TXRD_STATS_EN
        , .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural show-ahead-free FIFO: data one clock after the read request.
    logic [63:0] mem [0:4095];
    int wr_ptr = 0, rd_ptr = 0, underrun = 0;
    assign fifo_rdempty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rdreq) begin
            if (rd_ptr == wr_ptr) underrun <= underrun + 1;
            else begin
                fifo_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic        e;
        logic [2:0]  m;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc[$];
    int    errors = 0, checks = 0;
    int    cyc = 0, beats = 0, lerr = 0;
    logic  stall = 1'b0, toggle = 1'b0;
    beat_t held;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic push_data(input logic [63:0] w, input logic s, input logic e, input logic [2:0] m);
        push_word(w);
        exp_q.push_back('{d: w, s: s, e: e, m: m});
    endtask

    // Descriptor with junk in the upper bits, then its words; beats expected only if legal.
    task automatic push_pkt(input int len);
        int words;
        logic legal;
        logic [63:0] w;
        logic [15:0] l16;
        l16   = 16'(len);
        words = (len + 7) / 8;
        legal = (len > 0) && (len <= 9600);
        push_word({$urandom(), 16'hBEEF, l16});
        for (int i = 0; i < words; i++) begin
            w = {$urandom(), $urandom()};
            if (legal) push_data(w, i == 0, i == words - 1, (i == words - 1) ? l16[2:0] : 3'd0);
            else push_word(w);
        end
    endtask

    // Observe outputs at the falling edge, then drive tx_rdy just after the rising edge.
    task automatic tick();
        beat_t cur, e;
        @(negedge clk);
        cur = '{d: tx_data, s: tx_sop, e: tx_eop, m: tx_mod};
        if (len_err === 1'b1) lerr++;
        if (stall) chk("stall_hold", {tx_val, cur}, {1'b1, held});
        if (tx_val === 1'b1 && tx_rdy === 1'b1) begin
            beats++;
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_beat", 128'(exp_q.size()), 128'd1);
            else begin
                e = exp_q.pop_front();
                chk("beat", cur, e);
            end
        end
        stall = (tx_val === 1'b1) && (tx_rdy === 1'b0);
        held  = cur;
        @(posedge clk);
        cyc++;
        #1;
        tx_rdy = toggle ? ~tx_rdy : 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && busy === 1'b0 && fifo_rdempty) break;
        end
        chk(tag, 128'(i < budget), 128'd1);
    endtask

    initial begin
        int b0, l0, r0;

        // Reset held with a packet already waiting in the FIFO.
        push_pkt(20);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rdreq", 128'(fifo_rdreq), 128'd0);
        chk("rst_outs", {tx_val, tx_data, tx_sop, tx_eop, tx_mod, busy, len_err}, 128'd0);
        chk("rst_no_reads", 128'(rd_ptr), 128'd0);
`ifdef TXRD_STATS_EN
        chk("rst_stats", {pkt_cnt, byte_cnt}, 128'd0);
`endif
        @(posedge clk);
        #1;
        reset_ = 1'b1;

        // len=20: three back-to-back beats, mod=4 on EOP.
        beat_cyc.delete();
        drain("t2_drain", 50);
        chk("t2_beats", 128'(beat_cyc.size()), 128'd3);
        if (beat_cyc.size() == 3) chk("t2_back2back", 128'(beat_cyc[2] - beat_cyc[0]), 128'd2);

        // Two len=64 packets with the sink toggling ready every clock.
        b0 = beats;
        toggle = 1'b1;
        push_pkt(64);
        push_pkt(64);
        drain("t3_drain", 200);
        toggle = 1'b0;
        tx_rdy = 1'b1;
        chk("t3_beats", 128'(beats - b0), 128'd16);

        // len=0 is rejected with no beat; len=8 gives one SOP+EOP beat.
        b0 = beats;
        l0 = lerr;
        push_pkt(0);
        push_pkt(8);
        drain("t4_drain", 50);
        chk("t4_len_err", 128'(lerr - l0), 128'd1);
        chk("t4_beats", 128'(beats - b0), 128'd1);

        // Oversize packet: all 1250 words consumed silently, following packet intact.
        b0 = beats;
        l0 = lerr;
        r0 = rd_ptr;
        push_pkt(10000);
        push_pkt(20);
        drain("t5_drain", 4000);
        chk("t5_len_err", 128'(lerr - l0), 128'd1);
        chk("t5_beats", 128'(beats - b0), 128'd3);
        chk("t5_reads", 128'(rd_ptr - r0), 128'd1255);

        // Fresh reset, then statistics over the len=20 and 2x len=64 runs.
        reset_ = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
`ifdef TXRD_STATS_EN
        chk("t6_stats_rst", {pkt_cnt, byte_cnt}, 128'd0);
        push_pkt(20);
        drain("t6_drain_a", 50);
        toggle = 1'b1;
        push_pkt(64);
        push_pkt(64);
        drain("t6_drain_b", 200);
        toggle = 1'b0;
        tx_rdy = 1'b1;
        chk("t6_pkt_cnt", 128'(pkt_cnt), 128'd3);
        chk("t6_byte_cnt", 128'(byte_cnt), 128'd148);
`endif

        // FIFO underrun mid-packet: gap, then resume without a second SOP.
        push_word({32'h1234_5678, 16'h0, 16'd24});
        push_data({$urandom(), $urandom()}, 1'b1, 1'b0, 3'd0);
        repeat (6) tick();
        chk("ur_one_beat", 128'(exp_q.size()), 128'd0);
        chk("ur_gap_val", 128'(tx_val), 128'd0);
        chk("ur_busy", 128'(busy), 128'd1);
        push_data({$urandom(), $urandom()}, 1'b0, 1'b0, 3'd0);
        push_data({$urandom(), $urandom()}, 1'b0, 1'b1, 3'd0);
        drain("ur_drain", 50);

        chk("no_fifo_underrun", 128'(underrun), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
